// File: rtl/mips_fetch_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction-fetch stage in front of a synchronous instruction ROM. It owns
// the program counter, drives the ROM address and hides the ROM's one-cycle
// registered-address latency. It also presents a valid-qualified IF/ID
// register to decode, with a decode stall and a branch/jump redirect that
// flushes the register.
//
// Parameters
//   PC_WIDTH  width of the PC and ROM address (byte address, word aligned)
//   RESET_PC  first PC fetched after reset
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   rom_addr       ROM address; the ROM registers it on clk
//   rom_data       ROM word for the address latched on the previous edge
//   stall          decode stall: hold PC and IF/ID
//   redirect       taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc    redirect target byte address (low two bits ignored)
//   ifid_instr     IF/ID instruction
//   ifid_pc        IF/ID instruction address
//   ifid_pc_plus4  ifid_pc + 4, modulo 2^PC_WIDTH
//   ifid_valid     IF/ID holds a real instruction
//
// Optional build macro FETCH_PERF_EN adds:
//   perf_fetched   RUN-state edges that load a valid instruction
//   perf_bubbles   RUN-state edges that flush or stall
//
// State table
//   state | meaning
//   PRIME | ROM address register not loaded yet; rom_data is meaningless
//   RUN   | rom_data is the instruction at pc_q
// -----------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter int                     PC_WIDTH = 7,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [PC_WIDTH-1:0]   rom_addr,
    input  logic [31:0]           rom_data,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [31:0]           ifid_instr,
    output logic [PC_WIDTH-1:0]   ifid_pc,
    output logic [PC_WIDTH-1:0]   ifid_pc_plus4,
    output logic                  ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           perf_fetched,
    output logic [15:0]           perf_bubbles
`endif
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    state_t               state;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  target;

    assign pc_inc = pc_q + PC_STEP;
    assign target = redirect_pc & ALIGN_MASK;

    // The ROM registers rom_addr, so rom_addr must already be the PC that the
    // next cycle will own: the target on redirect, the same PC on a stall
    // (re-latch so rom_data stays put), otherwise the sequential PC.
    always_comb begin
        rom_addr = pc_q;
        if (redirect) begin
            rom_addr = target;
        end else if (state == RUN && !stall) begin
            rom_addr = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PRIME;
            pc_q          <= RESET_PC;
            ifid_instr    <= 32'h0000_0000;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_fetched  <= 16'h0000;
            perf_bubbles  <= 16'h0000;
`endif
        end else begin
            case (state)
                PRIME: begin
                    state <= RUN;
                    if (redirect) begin
                        pc_q <= target;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        // Flush: ifid_pc/ifid_pc_plus4 deliberately hold.
                        pc_q       <= target;
                        ifid_instr <= 32'h0000_0000;
                        ifid_valid <= 1'b0;
`ifdef FETCH_PERF_EN
                        perf_bubbles <= perf_bubbles + 16'h0001;
`endif
                    end else if (stall) begin
`ifdef FETCH_PERF_EN
                        perf_bubbles <= perf_bubbles + 16'h0001;
`endif
                    end else begin
                        pc_q          <= pc_inc;
                        ifid_instr    <= rom_data;
                        ifid_pc       <= pc_q;
                        ifid_pc_plus4 <= pc_inc;
                        ifid_valid    <= 1'b1;
`ifdef FETCH_PERF_EN
                        perf_fetched  <= perf_fetched + 16'h0001;
`endif
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
`timescale 1ns/1ps
module tb_mips_fetch_unit;

    localparam int W = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic [W-1:0]  rom_addr;
    logic [31:0]   rom_data;
    logic [31:0]   ifid_instr;
    logic [W-1:0]  ifid_pc;
    logic [W-1:0]  ifid_pc_plus4;
    logic          ifid_valid;
`ifdef FETCH_PERF_EN
    logic [15:0]   perf_fetched;
    logic [15:0]   perf_bubbles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_fetch_unit #(.PC_WIDTH(W), .RESET_PC(7'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    // Synchronous ROM: registers the address, returns the word next cycle.
    logic [31:0] mem [32];
    logic [4:0]  rom_a_q = '0;
    always @(posedge clk) rom_a_q <= rom_addr[W-1:2];
    assign rom_data = mem[rom_a_q];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch pointer (the address whose instruction is
    // the next one to hand to decode) plus the expected IF/ID contents,
    // reading instructions straight from the program image.
    bit            m_started;
    logic [W-1:0]  m_fetch;
    logic [31:0]   m_instr;
    logic [W-1:0]  m_pc;
    logic [W-1:0]  m_pc4;
    logic          m_valid;
    logic [15:0]   m_fet;
    logic [15:0]   m_bub;

    function automatic logic [W-1:0] align(input logic [W-1:0] a);
        return {a[W-1:2], 2'b00};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_fetch   <= 7'h00;
            m_instr   <= 32'h0;
            m_pc      <= '0;
            m_pc4     <= '0;
            m_valid   <= 1'b0;
            m_fet     <= 16'h0;
            m_bub     <= 16'h0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            if (redirect) m_fetch <= align(redirect_pc);
        end else if (redirect) begin
            m_fetch <= align(redirect_pc);
            m_instr <= 32'h0;
            m_valid <= 1'b0;
            m_bub   <= m_bub + 16'h1;
        end else if (stall) begin
            m_bub   <= m_bub + 16'h1;
        end else begin
            m_instr <= mem[m_fetch[W-1:2]];
            m_pc    <= m_fetch;
            m_pc4   <= m_fetch + W'(4);
            m_valid <= 1'b1;
            m_fetch <= m_fetch + W'(4);
            m_fet   <= m_fet + 16'h1;
        end
    end

    // Compare process: every negedge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [W-1:0] exp_addr;
            if (redirect)                 exp_addr = align(redirect_pc);
            else if (!m_started || stall) exp_addr = m_fetch;
            else                          exp_addr = m_fetch + W'(4);
            chk("cmp_rom_addr", 32'(rom_addr), 32'(exp_addr));
            chk("cmp_valid", 32'(ifid_valid), 32'(m_valid));
            chk("cmp_instr", ifid_instr, m_instr);
            chk("cmp_pc", 32'(ifid_pc), 32'(m_pc));
            chk("cmp_pc4", 32'(ifid_pc_plus4), 32'(m_pc4));
`ifdef FETCH_PERF_EN
            chk("cmp_perf_fetched", 32'(perf_fetched), 32'(m_fet));
            chk("cmp_perf_bubbles", 32'(perf_bubbles), 32'(m_bub));
`endif
        end
    end

    task automatic drive(input logic s, input logic r, input logic [W-1:0] rpc);
        stall = s;
        redirect = r;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_ifid(input string name, input logic [W-1:0] pc, input logic [31:0] instr);
        chk({name, "_valid"}, 32'(ifid_valid), 32'd1);
        chk({name, "_pc"}, 32'(ifid_pc), 32'(pc));
        chk({name, "_pc4"}, 32'(ifid_pc_plus4), 32'(pc + W'(4)));
        chk({name, "_instr"}, ifid_instr, instr);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h0273_4820;
        mem[1] = 32'h0273_4820;
        mem[2] = 32'h0236_4820;
        mem[3] = 32'h8d28_0000;

        // Straight-line fetch after reset.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        drive(0, 0, '0);
        chk("prime_addr", 32'(rom_addr), 32'h00);
        chk("prime_valid", 32'(ifid_valid), 32'd0);
        tick();
        chk("edge1_valid", 32'(ifid_valid), 32'd0);
        chk("edge1_addr", 32'(rom_addr), 32'h04);
        tick();
        chk_ifid("cap0", 7'h00, 32'h0273_4820);
        chk("cap0_addr", 32'(rom_addr), 32'h08);
        tick();
        chk_ifid("cap1", 7'h04, 32'h0273_4820);

        // Stall three cycles holding pc 04.
        drive(1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", 32'(rom_addr), 32'h08);
            tick();
            chk_ifid("stall_hold", 7'h04, 32'h0273_4820);
        end
        drive(0, 0, '0);
        tick();
        chk_ifid("after_stall", 7'h08, 32'h0236_4820);

        // Return to pc 04 (unaligned target 06).
        drive(0, 1, 7'h06);
        tick();
        drive(0, 0, '0);
        tick();
        chk_ifid("back_to_04", 7'h04, 32'h0273_4820);

        // Redirect to 0x0E while IF/ID holds 04.
        drive(0, 1, 7'h0E);
        chk("redir_addr", 32'(rom_addr), 32'h0C);
        tick();
        chk("redir_bubble_valid", 32'(ifid_valid), 32'd0);
        chk("redir_bubble_instr", ifid_instr, 32'h0);
        chk("redir_bubble_pc", 32'(ifid_pc), 32'h04);
        drive(0, 0, '0);
        tick();
        chk_ifid("redir_target", 7'h0C, 32'h8d28_0000);

        // Redirect and stall together: redirect wins.
        drive(1, 1, 7'h02);
        chk("rs_addr", 32'(rom_addr), 32'h00);
        tick();
        chk("rs_bubble_valid", 32'(ifid_valid), 32'd0);
        chk("rs_bubble_instr", ifid_instr, 32'h0);
        drive(0, 0, '0);
        tick();
        chk_ifid("rs_target", 7'h00, 32'h0273_4820);

        // Wrap-around at 0x7C.
        drive(0, 1, 7'h7E);
        chk("wrap_redir_addr", 32'(rom_addr), 32'h7C);
        tick();
        drive(0, 0, '0);
        chk("wrap_next_addr", 32'(rom_addr), 32'h00);
        tick();
        chk("wrap_pc", 32'(ifid_pc), 32'h7C);
        chk("wrap_pc4", 32'(ifid_pc_plus4), 32'h00);
        tick();
        chk("wrap_after_pc", 32'(ifid_pc), 32'h00);

        // Asynchronous reset mid-stream.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ifid_valid), 32'd0);
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_pc", 32'(ifid_pc), 32'h0);
        chk("arst_pc4", 32'(ifid_pc_plus4), 32'h0);
        chk("arst_addr", 32'(rom_addr), 32'h00);
`ifdef FETCH_PERF_EN
        chk("arst_perf_fetched", 32'(perf_fetched), 32'd0);
        chk("arst_perf_bubbles", 32'(perf_bubbles), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk_ifid("restart0", 7'h00, 32'h0273_4820);
        tick();
        tick();
        tick();
        chk_ifid("restart3", 7'h0C, 32'h8d28_0000);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_4", 32'(perf_fetched), 32'd4);
        chk("perf_bubbles_0", 32'(perf_bubbles), 32'd0);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom));
                tick();
                rst_n = 1'b1;
            end
            drive(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 12), 7'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
